// File: rtl/i2c_target.sv
// I2C target responder with a small byte register file.
// Answers DEV_ADDR, takes a register pointer, accepts writes and returns reads with
// pointer auto-increment. SCL/SDA are oversampled on clk; SDA is only ever pulled low.
// Optional: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample stable filter on scl/sda.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h48,
  parameter int unsigned REG_COUNT = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scl,
  inout  wire                    sda,
  output logic [8*REG_COUNT-1:0] regs_out,
  output logic                   wr_strobe,
  output logic [PTR_W-1:0]       wr_addr,
  output logic                   busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  state_e state_q, state_d;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_lvl, sda_lvl, scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_cond, stop_cond;

  logic [7:0]                  shift_q, shift_d;
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d, ptr_inc;
  logic                        ack_q, ack_d;
  logic [REG_COUNT-1:0][7:0]   regs_q, regs_d;
  logic                        sda_oe_q, sda_oe_d, wr_strobe_d;
  logic [PTR_W-1:0]            wr_addr_d;

  // Two-flop synchronisers for the bus pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // Level only follows the synchroniser once three consecutive samples agree
  always_comb begin
    scl_lvl = (scl_sync_q[1] == scl_hist_q[0] && scl_sync_q[1] == scl_hist_q[1]) ?
              scl_sync_q[1] : scl_filt_q;
    sda_lvl = (sda_sync_q[1] == sda_hist_q[0] && sda_sync_q[1] == sda_hist_q[1]) ?
              sda_sync_q[1] : sda_filt_q;
  end

  // Sample history and held filter output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_lvl;
      sda_filt_q <= sda_lvl;
    end
  end
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  // Previous levels for edge and bus-condition detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  assign scl_rise   = scl_lvl & ~scl_prev_q;
  assign scl_fall   = ~scl_lvl & scl_prev_q;
  assign start_cond = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop_cond  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;
  assign ptr_inc    = ptr_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; bytes complete on the 8th scl fall, ACK slots end on the 9th
  always_comb begin
    state_d = state_q;
    if (stop_cond) begin
      state_d = StIdle;
    end else if (start_cond) begin
      state_d = StAddr;
    end else if (scl_fall) begin
      case (state_q)
        StAddr:     if (bit_cnt_q == 4'd8) state_d = (shift_q[7:1] == DEV_ADDR) ? StAddrAck
                                                                               : StIgnore;
        StAddrAck:  state_d = shift_q[0] ? StRdata : StPtr;
        StPtr:      if (bit_cnt_q == 4'd8) state_d = StPtrAck;
        StPtrAck:   state_d = StWdata;
        StWdata:    if (bit_cnt_q == 4'd8) state_d = StWdataAck;
        StWdataAck: state_d = StWdata;
        StRdata:    if (bit_cnt_q == 4'd7) state_d = StRdataAck;
        StRdataAck: state_d = ack_q ? StIgnore : StRdata;
        default:    ;
      endcase
    end
  end

  // Datapath next-state: shift register, bit counter, pointer, register file
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    regs_d    = regs_q;
    if (start_cond || stop_cond) begin
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == StPtr) ptr_d = shift_q[PTR_W-1:0];
            if (state_q == StWdata) begin
              regs_d[ptr_q] = shift_q;
              ptr_d         = ptr_inc;
            end
          end
        end
        StAddrAck: if (scl_fall) begin
          bit_cnt_d = 4'd0;
          if (shift_q[0]) shift_d = regs_q[ptr_q];
        end
        StRdata: if (scl_fall) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
        StRdataAck: begin
          if (scl_rise) ack_d = sda_lvl;
          if (scl_fall && !ack_q) begin
            ptr_d   = ptr_inc;
            shift_d = regs_q[ptr_inc];
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic; sda drive is only re-evaluated on an scl fall
  always_comb begin
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr;
    busy        = state_q inside {StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck,
                                  StRdata, StRdataAck};
    if (start_cond || stop_cond) begin
      sda_oe_d = 1'b0;
    end else if (scl_fall) begin
      case (state_d)
        StAddrAck, StPtrAck, StWdataAck: sda_oe_d = 1'b1;
        StRdata:                         sda_oe_d = ~shift_d[7];
        default:                         sda_oe_d = 1'b0;
      endcase
      if (state_q == StWdata && bit_cnt_q == 4'd8) begin
        wr_strobe_d = 1'b1;
        wr_addr_d   = ptr_q;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= '0;
      ack_q     <= 1'b1;
      regs_q    <= '0;
      sda_oe_q  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      regs_q    <= regs_d;
      sda_oe_q  <= sda_oe_d;
      wr_strobe <= wr_strobe_d;
      wr_addr   <= wr_addr_d;
    end
  end

  assign regs_out = regs_q;
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;

endmodule
